clk_rst_seq: RTL and testbench
==============================

// Module: clk_rst_seq
// PURPOSE
//  Clock/reset sequencer that sits directly upstream of the clocking block and drives it.
//  - Runs on clk_25M.
//  - Holds the PLL/DCM reset until its timing is met.
//  - Qualifies the lock signals (main, rx, tx) for stability.
//  - Releases the sys, rx and tx domain resets in a fixed order: sys, then rx, then tx.
//  - Re-runs the whole sequence on any loss of lock.
//  - Retries a bounded number of times, then reports a hard failure.
// PARAMETERS
//  PLL_RST_CYC       16     cycles pll_rst is held high per attempt (>=1)
//  LOCK_STABLE_CYC   1024   consecutive all-locked cycles required before release (>=1)
//  LOCK_TIMEOUT_CYC  65535  max cycles in WAIT_LOCK before the attempt fails (>LOCK_STABLE_CYC)
//  STAGE_GAP_CYC     64     cycles between successive domain reset releases (>=1)
//  MAX_RETRY         3      extra PLL reset attempts after the first timeout (0..15)
// PORTS
//  clk_25M      in   1  board reference clock; sole clock of this block
//  rst_n        in   1  asynchronous active-low reset
//  lock_main    in   1  PLL lock, main/sys clocks (async, 2-FF synchronised inside)
//  lock_rx      in   1  PLL lock, rx serdes clocks (async, 2-FF synchronised)
//  lock_tx      in   1  PLL lock, tx serdes clocks (async, 2-FF synchronised)
//  pll_rst      out  1  active-high reset to all PLLs/DCMs
//  rst_sys_n    out  1  sys-domain reset, active low
//  rst_rx_n     out  1  rx-domain reset, active low
//  rst_tx_n     out  1  tx-domain reset, active low
//  seq_done     out  1  1 while in RUN
//  seq_fail     out  1  1 while in FAIL (sticky until rst_n)
//  lock_lost    out  1  sticky: lock dropped after first release; cleared only by rst_n
//  retry_cnt    out  4  timeouts taken in current sequence
// BEHAVIOUR
//  Reset values (rst_n=0):
//  - state=PLL_RST, pll_rst=1.
//  - rst_sys_n=rst_rx_n=rst_tx_n=0.
//  - seq_done=seq_fail=lock_lost=0, retry_cnt=0.
//  - Synchronisers=0, counters=0.
//  All outputs are registered.
//  all_lock = AND of the three synchronised locks. Each lock input has 2 cycles of sync latency.
//  Single 16-bit cycle counter cnt; cleared on every state change. Separate 16-bit stable counter scnt.
//  States:
//  - PLL_RST: pll_rst=1, all rst_*_n=0. When cnt==PLL_RST_CYC-1: go to WAIT_LOCK, pll_rst=0.
//  - WAIT_LOCK: scnt increments while all_lock=1 and clears when all_lock=0. cnt increments every cycle.
//      - scnt==LOCK_STABLE_CYC-1 with all_lock=1: go to REL_SYS, rst_sys_n=1 on the same edge.
//      - Else cnt==LOCK_TIMEOUT_CYC-1: if retry_cnt==MAX_RETRY go to FAIL, else retry_cnt++ and go to PLL_RST.
//      - If stability completes on the timeout cycle, stability wins.
//  - REL_SYS: when cnt==STAGE_GAP_CYC-1: go to REL_RX, rst_rx_n=1.
//  - REL_RX: when cnt==STAGE_GAP_CYC-1: go to RUN, rst_tx_n=1, seq_done=1, retry_cnt=0.
//  - RUN: hold all outputs.
//  - FAIL: pll_rst=0, all rst_*_n=0, seq_fail=1. Terminal; exit only via rst_n.
//  Lock loss (all_lock=0 in REL_SYS, REL_RX or RUN) has priority over stage advance:
//  - On the next edge, all rst_*_n=0 simultaneously, seq_done=0, lock_lost=1, pll_rst=1, state=PLL_RST.
//  - retry_cnt is unchanged.
//  rst_n asserted mid-sequence: all outputs return to reset values immediately (asynchronous).
//  rst_n deassertion: the state machine acts only on the edges after rst_n has been synchronised (2 cycles).
//  Reset outputs never glitch: each changes only on a clk_25M edge, at most once per state transition.
// TESTING (bench params: PLL_RST_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=100,
//          STAGE_GAP_CYC=3, MAX_RETRY=2; clk_25M period 40 ns)
//  1. Locks held high from power-up, rst_n rises at 200 ns:
//     - pll_rst stays high 4 cycles.
//     - rst_sys_n rises 8 cycles after pll_rst falls.
//     - rst_rx_n rises +3 cycles, rst_tx_n rises +3 cycles; seq_done=1 with rst_tx_n.
//  2. lock_rx toggles low 1 cycle every 6 cycles, then stays high:
//     - No release until 8 consecutive synchronised all-locked cycles.
//     - scnt restarts on every drop.
//  3. Locks never assert:
//     - Three WAIT_LOCK timeouts of 100 cycles each, separated by 4-cycle pll_rst pulses; retry_cnt goes 1, 2.
//     - Then FAIL: seq_fail=1, pll_rst=0, all resets low.
//  4. In RUN, drop lock_tx for 1 cycle:
//     - Within 3 cycles (2 sync + 1 edge), all rst_*_n=0 together and lock_lost=1.
//     - Full sequence repeats; lock_lost stays 1.
//  5. Drop lock_main during REL_SYS at the cycle the gap expires:
//     - Lock loss wins; rst_rx_n stays 0 and state returns to PLL_RST.
//  6. Assert rst_n during REL_RX:
//     - All outputs return to reset values asynchronously, before the next clk_25M edge.
//     - After rst_n rises, the sequence restarts cleanly; lock_lost=0.

Source files
------------

// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer: pulses the PLL reset, qualifies the three lock inputs and
// releases the sys, rx and tx domain resets in order, retrying a bounded number of times.
module clk_rst_seq #(
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 65535,
  parameter int STAGE_GAP_CYC    = 64,
  parameter int MAX_RETRY        = 3
) (
  input  logic       clk_25M,
  input  logic       rst_n,
  input  logic       lock_main,
  input  logic       lock_rx,
  input  logic       lock_tx,
  output logic       pll_rst,
  output logic       rst_sys_n,
  output logic       rst_rx_n,
  output logic       rst_tx_n,
  output logic       seq_done,
  output logic       seq_fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam logic [15:0] PLL_LAST     = 16'(PLL_RST_CYC - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [15:0] GAP_LAST     = 16'(STAGE_GAP_CYC - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_REL_SYS,
    ST_REL_RX,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [15:0] scnt_reg;
  logic [1:0]  rst_sync_reg;
  logic        run_en;
  logic [2:0]  lock_async;
  logic [2:0]  lock_sync;
  logic        all_lock;
  logic        lose_now;

  // The sequencer only starts once the rst_n release has been re-timed to clk_25M.
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign run_en     = rst_sync_reg[1];
  assign lock_async = {lock_tx, lock_rx, lock_main};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lock_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= lock_async[gi];
          s2_reg <= s1_reg;
        end
      end
      assign lock_sync[gi] = s2_reg;
    end
  endgenerate

  assign all_lock = &lock_sync;

  // Losing lock after the first release outranks any stage advance.
  always_comb begin
    lose_now = 1'b0;
    if (!all_lock && (state_reg == ST_REL_SYS || state_reg == ST_REL_RX ||
                      state_reg == ST_RUN)) begin
      lose_now = 1'b1;
    end
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_PLL_RST;
      cnt_reg   <= 16'd0;
      scnt_reg  <= 16'd0;
      pll_rst   <= 1'b1;
      rst_sys_n <= 1'b0;
      rst_rx_n  <= 1'b0;
      rst_tx_n  <= 1'b0;
      seq_done  <= 1'b0;
      seq_fail  <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= 4'd0;
    end else if (run_en) begin
      if (lose_now) begin
        state_reg <= ST_PLL_RST;
        cnt_reg   <= 16'd0;
        scnt_reg  <= 16'd0;
        pll_rst   <= 1'b1;
        rst_sys_n <= 1'b0;
        rst_rx_n  <= 1'b0;
        rst_tx_n  <= 1'b0;
        seq_done  <= 1'b0;
        lock_lost <= 1'b1;
      end else begin
        case (state_reg)
          ST_PLL_RST: begin
            scnt_reg <= 16'd0;
            if (cnt_reg == PLL_LAST) begin
              state_reg <= ST_WAIT_LOCK;
              cnt_reg   <= 16'd0;
              pll_rst   <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
          ST_WAIT_LOCK: begin
            // Stability is tested first so it wins on the timeout cycle.
            if (all_lock && scnt_reg == STABLE_LAST) begin
              state_reg <= ST_REL_SYS;
              cnt_reg   <= 16'd0;
              scnt_reg  <= 16'd0;
              rst_sys_n <= 1'b1;
            end else if (cnt_reg == TIMEOUT_LAST) begin
              cnt_reg  <= 16'd0;
              scnt_reg <= 16'd0;
              if (retry_cnt == RETRY_MAX) begin
                state_reg <= ST_FAIL;
                seq_fail  <= 1'b1;
              end else begin
                state_reg <= ST_PLL_RST;
                retry_cnt <= retry_cnt + 4'd1;
                pll_rst   <= 1'b1;
              end
            end else begin
              cnt_reg  <= cnt_reg + 16'd1;
              scnt_reg <= all_lock ? scnt_reg + 16'd1 : 16'd0;
            end
          end
          ST_REL_SYS: begin
            if (cnt_reg == GAP_LAST) begin
              state_reg <= ST_REL_RX;
              cnt_reg   <= 16'd0;
              rst_rx_n  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
          ST_REL_RX: begin
            if (cnt_reg == GAP_LAST) begin
              state_reg <= ST_RUN;
              cnt_reg   <= 16'd0;
              rst_tx_n  <= 1'b1;
              seq_done  <= 1'b1;
              retry_cnt <= 4'd0;
            end else begin
              cnt_reg <= cnt_reg + 16'd1;
            end
          end
          ST_RUN: begin
            cnt_reg <= 16'd0;
          end
          ST_FAIL: begin
            pll_rst   <= 1'b0;
            rst_sys_n <= 1'b0;
            rst_rx_n  <= 1'b0;
            rst_tx_n  <= 1'b0;
            seq_done  <= 1'b0;
            seq_fail  <= 1'b1;
          end
          default: begin
            state_reg <= ST_PLL_RST;
            cnt_reg   <= 16'd0;
            scnt_reg  <= 16'd0;
            pll_rst   <= 1'b1;
            rst_sys_n <= 1'b0;
            rst_rx_n  <= 1'b0;
            rst_tx_n  <= 1'b0;
            seq_done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Scoreboard bench for clk_rst_seq: stimulus queues hand-computed output changes
// (cycle number + output vector); a negedge monitor checks every change the DUT makes.
module tb_clk_rst_seq;

  logic       clk_25M   = 1'b0;
  logic       rst_n     = 1'b1;
  logic       lock_main = 1'b1;
  logic       lock_rx   = 1'b1;
  logic       lock_tx   = 1'b1;
  logic       pll_rst, rst_sys_n, rst_rx_n, rst_tx_n;
  logic       seq_done, seq_fail, lock_lost;
  logic [3:0] retry_cnt;

  clk_rst_seq #(
    .PLL_RST_CYC(4), .LOCK_STABLE_CYC(8), .LOCK_TIMEOUT_CYC(100),
    .STAGE_GAP_CYC(3), .MAX_RETRY(2)
  ) dut (
    .clk_25M(clk_25M), .rst_n(rst_n),
    .lock_main(lock_main), .lock_rx(lock_rx), .lock_tx(lock_tx),
    .pll_rst(pll_rst), .rst_sys_n(rst_sys_n), .rst_rx_n(rst_rx_n), .rst_tx_n(rst_tx_n),
    .seq_done(seq_done), .seq_fail(seq_fail), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
  );

  always #20 clk_25M = ~clk_25M;

  int cyc = 0;
  always @(posedge clk_25M) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [10:0] s;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Vector order: {pll_rst, sys, rx, tx, done, fail, lost} then retry_cnt.
  function automatic logic [10:0] mk(input logic [6:0] b, input logic [3:0] r);
    return {b, r};
  endfunction

  function automatic logic [10:0] snap();
    return {pll_rst, rst_sys_n, rst_rx_n, rst_tx_n, seq_done, seq_fail, lock_lost, retry_cnt};
  endfunction

  task automatic push(input int c, input logic [10:0] s);
    exp_q.push_back('{c, s});
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk_25M);
      #5;
    end
  endtask

  // Clean sequence with locks already stable: pll falls at +6, sys +14, rx +17, tx/done +20.
  task automatic push_clean(input int c0, input logic lost);
    push(c0 + 6,  mk({6'b000000, lost}, 4'd0));
    push(c0 + 14, mk({6'b010000, lost}, 4'd0));
    push(c0 + 17, mk({6'b011000, lost}, 4'd0));
    push(c0 + 20, mk({6'b011110, lost}, 4'd0));
  endtask

  task automatic assert_rst();
    push(cyc, mk(7'b1000000, 4'd0));
    rst_n = 1'b0;
  endtask

  initial begin : monitor
    logic [10:0] prev;
    logic [10:0] cur;
    exp_t        e;
    @(negedge clk_25M);
    cur = snap();
    checks++;
    if (cur !== mk(7'b1000000, 4'd0)) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", cur, mk(7'b1000000, 4'd0));
    end else begin
      $display("ok   reset_state cyc=%0d out=%b", cyc, cur);
    end
    prev = cur;
    forever begin
      @(negedge clk_25M);
      cur = snap();
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%b exp=none", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.c != cyc || e.s !== cur) begin
            failures++;
            $display("FAIL out_change got cyc=%0d out=%b exp cyc=%0d out=%b", cyc, cur, e.c, e.s);
          end else begin
            $display("ok   out_change cyc=%0d out=%b", cyc, cur);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : stim
    int c0;
    logic [10:0] now;
    // 1: locks high from power-up, rst_n rises at 200 ns.
    #5 rst_n = 1'b0;
    #195;
    c0 = cyc;
    push_clean(c0, 1'b0);
    rst_n = 1'b1;
    at_cyc(c0 + 25);

    // 4: one-cycle lock_tx drop in RUN; loss seen 3 edges later, then full resequence.
    c0 = cyc;
    push(c0 + 3, mk(7'b1000001, 4'd0));
    push_clean(c0 + 1, 1'b1);
    lock_tx = 1'b0;
    at_cyc(c0 + 1);
    lock_tx = 1'b1;
    at_cyc(c0 + 26);

    // 5: lock_main low so the synchronised drop lands on the REL_SYS gap-expiry edge.
    assert_rst();
    at_cyc(cyc + 3);
    c0 = cyc;
    push(c0 + 6,  mk(7'b0000000, 4'd0));
    push(c0 + 14, mk(7'b0100000, 4'd0));
    push(c0 + 17, mk(7'b1000001, 4'd0));
    push(c0 + 21, mk(7'b0000001, 4'd0));
    push(c0 + 29, mk(7'b0100001, 4'd0));
    push(c0 + 32, mk(7'b0110001, 4'd0));
    rst_n = 1'b1;
    at_cyc(c0 + 14);
    lock_main = 1'b0;
    at_cyc(c0 + 15);
    lock_main = 1'b1;

    // 6: rst_n during REL_RX of the resequence; outputs must clear before the next edge.
    at_cyc(c0 + 33);
    assert_rst();
    #1;
    now = snap();
    checks++;
    if (now !== mk(7'b1000000, 4'd0)) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", now, mk(7'b1000000, 4'd0));
    end else begin
      $display("ok   async_reset cyc=%0d out=%b", cyc, now);
    end
    at_cyc(c0 + 36);
    c0 = cyc;
    push_clean(c0, 1'b0);
    rst_n = 1'b1;
    at_cyc(c0 + 25);

    // 2: lock_rx low for one cycle at +4, +10, +16; last restart at edge +19 -> sys at +27.
    assert_rst();
    at_cyc(cyc + 3);
    c0 = cyc;
    push(c0 + 6,  mk(7'b0000000, 4'd0));
    push(c0 + 27, mk(7'b0100000, 4'd0));
    push(c0 + 30, mk(7'b0110000, 4'd0));
    push(c0 + 33, mk(7'b0111100, 4'd0));
    rst_n = 1'b1;
    for (int k = 4; k <= 16; k += 6) begin
      at_cyc(c0 + k);
      lock_rx = 1'b0;
      at_cyc(c0 + k + 1);
      lock_rx = 1'b1;
    end
    at_cyc(c0 + 38);

    // Retry then success: one timeout, locks come up in the second attempt, retry_cnt clears in RUN.
    assert_rst();
    lock_main = 1'b0; lock_rx = 1'b0; lock_tx = 1'b0;
    at_cyc(cyc + 3);
    c0 = cyc;
    push(c0 + 6,   mk(7'b0000000, 4'd0));
    push(c0 + 106, mk(7'b1000000, 4'd1));
    push(c0 + 110, mk(7'b0000000, 4'd1));
    push(c0 + 118, mk(7'b0100000, 4'd1));
    push(c0 + 121, mk(7'b0110000, 4'd1));
    push(c0 + 124, mk(7'b0111100, 4'd0));
    rst_n = 1'b1;
    at_cyc(c0 + 107);
    lock_main = 1'b1; lock_rx = 1'b1; lock_tx = 1'b1;
    at_cyc(c0 + 130);

    // 3: locks never assert -> three 100-cycle timeouts, then FAIL with retry_cnt=2.
    assert_rst();
    lock_main = 1'b0; lock_rx = 1'b0; lock_tx = 1'b0;
    at_cyc(cyc + 3);
    c0 = cyc;
    push(c0 + 6,   mk(7'b0000000, 4'd0));
    push(c0 + 106, mk(7'b1000000, 4'd1));
    push(c0 + 110, mk(7'b0000000, 4'd1));
    push(c0 + 210, mk(7'b1000000, 4'd2));
    push(c0 + 214, mk(7'b0000000, 4'd2));
    push(c0 + 314, mk(7'b0000010, 4'd2));
    rst_n = 1'b1;
    at_cyc(c0 + 330);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0 next_cyc=%0d next_out=%b",
               exp_q.size(), exp_q[0].c, exp_q[0].s);
    end else begin
      $display("ok   drain pending=0");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
